// File: rtl/micro_alpha_veryl_demux.sv
// Registered 1:2 valid/ready demultiplexer with one-entry output slots and per-destination handshake counters.
// Optional broadcast mode (load both slots at once) is enabled by defining MICRO_ALPHA_VERYL_DEMUX_BROADCAST_EN.
module micro_alpha_veryl_demux #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             selector,
`ifdef MICRO_ALPHA_VERYL_DEMUX_BROADCAST_EN
    input  logic             broadcast,
`endif
    output logic [WIDTH-1:0] dout0,
    output logic             dout0_valid,
    input  logic             dout0_ready,
    output logic [WIDTH-1:0] dout1,
    output logic             dout1_valid,
    input  logic             dout1_ready,
    output logic [15:0]      count0,
    output logic [15:0]      count1
);

    // Handshake: a word moves on any edge where its valid and ready are both 1.
    // din_ready never depends on din_valid, so an upstream may wait on it safely.
    logic [WIDTH-1:0] r_dout0;
    logic [WIDTH-1:0] r_dout1;
    logic             r_valid0;
    logic             r_valid1;
    logic [15:0]      r_count0;
    logic [15:0]      r_count1;

    logic w_bcast;
    logic w_free0;
    logic w_free1;
    logic w_accept;
    logic w_acc0;
    logic w_acc1;
    logic w_drain0;
    logic w_drain1;

`ifdef MICRO_ALPHA_VERYL_DEMUX_BROADCAST_EN
    assign w_bcast = broadcast;
`else
    assign w_bcast = 1'b0;
`endif

    assign w_free0  = !r_valid0 || dout0_ready;
    assign w_free1  = !r_valid1 || dout1_ready;
    // Broadcast waits for both slots so a word is never delivered to only one side.
    assign din_ready = w_bcast ? (w_free0 && w_free1)
                               : (selector ? w_free1 : w_free0);
    assign w_accept = din_valid && din_ready;
    assign w_acc0   = w_accept && (w_bcast || !selector);
    assign w_acc1   = w_accept && (w_bcast || selector);
    assign w_drain0 = r_valid0 && dout0_ready;
    assign w_drain1 = r_valid1 && dout1_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dout0  <= '0;
            r_dout1  <= '0;
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
            r_count0 <= '0;
            r_count1 <= '0;
        end else begin
            if (w_acc0) begin
                r_dout0  <= din;
                r_valid0 <= 1'b1;
            end else if (w_drain0) begin
                r_valid0 <= 1'b0;
            end
            if (w_acc1) begin
                r_dout1  <= din;
                r_valid1 <= 1'b1;
            end else if (w_drain1) begin
                r_valid1 <= 1'b0;
            end
            if (w_drain0) r_count0 <= r_count0 + 16'd1;
            if (w_drain1) r_count1 <= r_count1 + 16'd1;
        end
    end

    assign dout0       = r_dout0;
    assign dout1       = r_dout1;
    assign dout0_valid = r_valid0;
    assign dout1_valid = r_valid1;
    assign count0      = r_count0;
    assign count1      = r_count1;

endmodule
